// File: rtl/dmem_subsystem.sv
// Data-side memory for the CPU MEM stage: word RAM plus an MMIO window (TX FIFO, STATUS, CYCLE).
// Latency: reads are combinational (same cycle); writes take effect on the next rising edge.
// Backpressure: none toward the CPU; a TX push into a full, non-draining FIFO is dropped and flagged.
module dmem_subsystem #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] MMIO_PAGE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_read_en,
  input  logic        d_write_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_write_data,
  output logic [31:0] d_data_out,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int CW  = FPW + 1;

  localparam logic [7:0] OFF_TX     = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLE  = 8'h08;

  // Storage
  logic [31:0]    ram_q      [RAM_WORDS];
  logic [31:0]    fifo_mem_q [FIFO_DEPTH];

  logic [FPW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FPW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q,  count_d;
  logic           ovf_q,    ovf_d;
  logic [31:0]    cycle_q,  cycle_d;

  // Decode
  logic           is_mmio;
  logic [7:0]     mmio_off;
  logic [RAW-1:0] ram_idx;
  logic           ram_we;
  logic           push_req;
  logic           push_ok;
  logic           pop;
  logic           fifo_empty;
  logic           fifo_full;
  logic           status_wr;
  logic           cycle_wr;
  logic [4:0]     count5;
  logic [31:0]    mmio_rd;
  logic           unused_addr;

  // Every address bit feeds some decode in some configuration; fold them so none is left dangling.
  assign unused_addr = ^d_addr;

  // Address decode, FIFO handshake terms and write strobes
  always_comb begin
    is_mmio    = (d_addr[31:16] == MMIO_PAGE);
    mmio_off   = d_addr[7:0];
    ram_idx    = d_addr[RAW+1:2];
    // Requests are ignored while reset is held; the RAM has no reset of its own, so gate it here.
    ram_we     = rst && d_write_en && !is_mmio;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = tx_valid && tx_ready;
    push_req   = d_write_en && is_mmio && (mmio_off == OFF_TX);
    // A full FIFO can still take a word when the head leaves on the same edge.
    push_ok    = push_req && (!fifo_full || pop);
    status_wr  = d_write_en && is_mmio && (mmio_off == OFF_STATUS);
    cycle_wr   = d_write_en && is_mmio && (mmio_off == OFF_CYCLE);
  end

  // FIFO pointer/count, sticky overflow and cycle counter next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cycle_d  = cycle_q + 32'd1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + FPW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + FPW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Clear and drop target different offsets, so they never collide.
    if (status_wr) begin
      ovf_d = 1'b0;
    end else if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end

    if (cycle_wr) begin
      cycle_d = d_write_data;
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cycle_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cycle_q  <= cycle_d;
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= d_write_data;
    end
  end

  // FIFO storage write; slot under rd_ptr is never overwritten while it is the valid head
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= d_write_data;
    end
  end

  // Drain port
  always_comb begin
    tx_valid = !fifo_empty;
    tx_data  = tx_valid ? fifo_mem_q[rd_ptr_q] : 32'd0;
  end

  // Read mux: pre-edge state only, no write bypass
  always_comb begin
    count5  = 5'(count_q);
    mmio_rd = 32'd0;
    case (mmio_off)
      OFF_STATUS: mmio_rd = {19'd0, count5, 5'd0, ovf_q, fifo_full, fifo_empty};
      OFF_CYCLE:  mmio_rd = cycle_q;
      default:    mmio_rd = 32'd0;
    endcase

    d_data_out = 32'd0;
    if (d_read_en) begin
      d_data_out = is_mmio ? mmio_rd : ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_subsystem.sv
// Directed bench for dmem_subsystem: RAM, TX FIFO, STATUS, CYCLE and asynchronous reset.
// Inputs change just after the falling edge; outputs are sampled 1 ns later, away from the rising edge.
// Expected values are hand-computed constants in each step.
module tb_dmem_subsystem;

  localparam logic [31:0] A_TX     = 32'hFFFF_0000;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0008;
  localparam logic [31:0] A_OTHER  = 32'hFFFF_000C;

  logic        clk;
  logic        rst;
  logic        d_read_en;
  logic        d_write_en;
  logic [31:0] d_addr;
  logic [31:0] d_write_data;
  logic [31:0] d_data_out;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  int n_cmp;
  int n_err;

  dmem_subsystem #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (4),
    .MMIO_PAGE  (16'hFFFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .d_read_en    (d_read_en),
    .d_write_en   (d_write_en),
    .d_addr       (d_addr),
    .d_write_data (d_write_data),
    .d_data_out   (d_data_out),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One write cycle: present after the falling edge, retire after the rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    d_read_en    = 1'b0;
    d_write_en   = 1'b1;
    d_addr       = a;
    d_write_data = d;
    @(posedge clk);
    #1;
    d_write_en   = 1'b0;
  endtask

  // One read cycle, checked combinationally before the next rising edge.
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    d_write_en = 1'b0;
    d_read_en  = 1'b1;
    d_addr     = a;
    #1;
    check(tag, d_data_out, exp);
    d_read_en  = 1'b0;
  endtask

  initial begin
    n_cmp        = 0;
    n_err        = 0;
    rst          = 1'b0;
    d_read_en    = 1'b0;
    d_write_en   = 1'b0;
    d_addr       = 32'd0;
    d_write_data = 32'd0;
    tx_ready     = 1'b0;

    // Reset state, observed while reset is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    d_read_en = 1'b1;
    d_addr    = A_STATUS;
    #1;
    check("rst_status", d_data_out, 32'h0000_0001);
    d_addr    = A_CYCLE;
    #1;
    check("rst_cycle", d_data_out, 32'd0);
    d_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // RAM write, read, alias, read disabled
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    rd_chk("ram_alias", 32'h0000_1013, 32'hDEAD_BEEF);
    @(negedge clk);
    d_read_en = 1'b0;
    d_addr    = 32'h0000_0010;
    #1;
    check("ram_rd_off", d_data_out, 32'd0);

    // Read and write to the same word together: read sees the old value
    wr(32'h0000_0020, 32'h1111_1111);
    @(negedge clk);
    d_read_en    = 1'b1;
    d_write_en   = 1'b1;
    d_addr       = 32'h0000_0020;
    d_write_data = 32'h2222_2222;
    #1;
    check("ram_rw_old", d_data_out, 32'h1111_1111);
    @(posedge clk);
    #1;
    d_read_en  = 1'b0;
    d_write_en = 1'b0;
    rd_chk("ram_rw_new", 32'h0000_0020, 32'h2222_2222);

    // Write-only and unmapped offsets read zero
    rd_chk("tx_reg_rd0", A_TX, 32'd0);
    rd_chk("other_rd0", A_OTHER, 32'd0);

    // FIFO fill and overflow
    for (int i = 1; i <= 4; i++) wr(A_TX, 32'(i));
    rd_chk("fill_status", A_STATUS, 32'h0000_0402);
    wr(A_TX, 32'd5);
    rd_chk("ovf_status", A_STATUS, 32'h0000_0406);
    check("ovf_head", tx_data, 32'd1);
    wr(A_STATUS, 32'd0);
    rd_chk("ovf_clear", A_STATUS, 32'h0000_0402);

    // Drain: one word per cycle in push order
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_vld", {31'd0, tx_valid}, 32'd1);
      check("drain_dat", tx_data, 32'(i));
      @(negedge clk);
    end
    #1;
    check("drain_empty_vld", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
    rd_chk("drain_status", A_STATUS, 32'h0000_0001);

    // Push into a full FIFO while the head leaves
    for (int i = 1; i <= 4; i++) wr(A_TX, 32'(i));
    @(negedge clk);
    tx_ready     = 1'b1;
    d_write_en   = 1'b1;
    d_addr       = A_TX;
    d_write_data = 32'd9;
    #1;
    check("pp_head", tx_data, 32'd1);
    @(posedge clk);
    #1;
    d_write_en = 1'b0;
    tx_ready   = 1'b0;
    rd_chk("pp_status", A_STATUS, 32'h0000_0402);
    @(negedge clk);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_seq [4];
      exp_seq = '{32'd2, 32'd3, 32'd4, 32'd9};
      #1;
      check("pp_drain", tx_data, exp_seq[i]);
      @(negedge clk);
    end
    #1;
    check("pp_empty_vld", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Cycle counter load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd_chk("cyc_load", A_CYCLE, 32'hFFFF_FFFE);
    rd_chk("cyc_plus1", A_CYCLE, 32'hFFFF_FFFF);
    rd_chk("cyc_wrap", A_CYCLE, 32'h0000_0000);

    // Mid-operation asynchronous reset with 3 entries and overflow set
    wr(A_TX, 32'hA);
    wr(A_TX, 32'hB);
    wr(A_TX, 32'hC);
    wr(A_TX, 32'hD);
    wr(A_TX, 32'hE);
    @(negedge clk);
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    rd_chk("pre_rst_status", A_STATUS, 32'h0000_0304);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("arst_tx_data", tx_data, 32'd0);
    d_read_en = 1'b1;
    d_addr    = A_STATUS;
    #1;
    check("arst_status", d_data_out, 32'h0000_0001);
    d_addr    = A_CYCLE;
    #1;
    check("arst_cycle", d_data_out, 32'd0);
    d_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_chk("ram_after_rst", 32'h0000_0010, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
